// File: rtl/jk_pkg.sv
// Shared JK helpers: direction encoding plus per-bit excitation and characteristic functions.
package jk_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Exact inverse of the characteristic; never produces J=K=1.
    function automatic logic [1:0] jk_excite(input logic q, input logic n);
        return {~q & n, q & ~n};
    endfunction

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        return (j & ~q) | (~k & q);
    endfunction

endpackage

// File: rtl/jk_excitation_counter_if.sv
// Control and observation bundle for the JK excitation counter.
interface jk_excitation_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] J_vec;
    logic [WIDTH-1:0] K_vec;
    logic             tc;

    modport master (
        output en, up_dn, load, load_val,
        input  Q, J_vec, K_vec, tc
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output Q, J_vec, K_vec, tc
    );
endinterface

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low clear.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Q <= 1'b0;
        end else begin
            Q <= jk_next(Q, J, K);
        end
    end

endmodule

// File: rtl/jk_excitation_counter.sv
// Modulo-MODULUS up/down counter built on a JK bank; next state is turned into J/K excitation.
module jk_excitation_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    jk_excitation_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MOD_MAX = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $fatal(1, "jk_excitation_counter: MODULUS %0d illegal for WIDTH %0d", MODULUS, WIDTH);
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    always_comb begin
        n = q;
        if (bus.load) begin
            n = (bus.load_val > MOD_MAX) ? MOD_MAX : bus.load_val;
        end else if (bus.en) begin
            if (bus.up_dn == DIR_UP) begin
                // >= also pulls an out-of-range state back to 0
                n = (q >= MOD_MAX) ? '0 : q + WIDTH'(1);
            end else begin
                n = (q == '0 || q > MOD_MAX) ? MOD_MAX : q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            {j[i], k[i]} = jk_excite(q[i], n[i]);
        end
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .J     (j[i]),
            .K     (k[i]),
            .Q     (q[i])
        );
    end

    assign bus.Q     = q;
    assign bus.J_vec = j;
    assign bus.K_vec = k;
    assign bus.tc    = bus.en & ~bus.load &
                       (((bus.up_dn == DIR_UP)   & (q == MOD_MAX)) |
                        ((bus.up_dn == DIR_DOWN) & (q == '0)));

endmodule

// File: doc/jk_excitation_counter.md
Name: jk_excitation_counter

Overview:
Modulo-N up/down counter whose state register is a bank of JK flip-flops. It derives the J/K excitation from the current state and the desired next state, which is the inverse of the JK characteristic equation. It serves as the design-side counterpart to the JK flip-flop primitive and is the reference counter for later sequence/timer blocks. It exposes the excitation vectors so the JK bank can be checked independently of the next-state logic.

Parameters:
WIDTH, 4, state width in bits.
MODULUS, 10, count modulus; legal range 2..2**WIDTH; state range 0..MODULUS-1.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset; 0 clears all state immediately
en  input  1  count enable
up_dn  input  1  direction: 1 counts up, 0 counts down
load  input  1  synchronous load request; overrides en
load_val  input  WIDTH  value to load
Q  output  WIDTH  current count (JK bank outputs)
J_vec  output  WIDTH  J excitation currently applied to each cell
K_vec  output  WIDTH  K excitation currently applied to each cell
tc  output  1  terminal count; high in the cycle a wrap will occur

Behaviour:
- Clocking and reset:
  - Single clock domain; all cells update on the rising edge of clk.
  - reset=0 asynchronously forces Q=0, with no clock required.
  - While reset=0, Q holds 0 regardless of other inputs.
  - J_vec, K_vec and tc are combinational and reflect Q=0 during reset.
  - Release of reset takes effect on the next rising edge.
- Next-state N, in priority order:
  - load=1: N = load_val if load_val < MODULUS, else N = MODULUS-1 (saturate).
  - load=0, en=1, up_dn=1: N = Q+1, or 0 if Q == MODULUS-1.
  - load=0, en=1, up_dn=0: N = Q-1, or MODULUS-1 if Q == 0.
  - load=0, en=0: N = Q (hold).
- Excitation is exact per bit, with no don't-care freedom, so verification can check it bit-for-bit:
  - J_i = ~Q_i & N_i
  - K_i = Q_i & ~N_i
  - Hold therefore yields J=K=0 on every bit.
  - The J=K=1 (toggle) combination is never generated.
- JK cell characteristic: Q_i <= (J_i & ~Q_i) | (~K_i & Q_i).
- Latency: one cycle from input sample to Q update.
- tc = en & ~load & ((up_dn & Q==MODULUS-1) | (~up_dn & Q==0)). It is combinational, so it is high in the cycle before the wrap edge.
- Illegal state recovery:
  - A Q >= MODULUS state is unreachable by design.
  - If Q >= MODULUS is ever present (e.g. X-injection in sim), the next count-up goes to 0 and the next count-down goes to MODULUS-1.
- Simultaneous events:
  - load and en together: load wins.
  - A reset assertion mid-count aborts immediately to 0.
  - Direction may change on any cycle; the new direction applies to that cycle's N.
- Width rule: all compares are done at WIDTH bits; MODULUS-1 must fit in WIDTH (elaboration-time check, fatal if violated).

Decomposition:
- Shared package jk_pkg:
  - Direction constants DIR_UP=1, DIR_DOWN=0.
  - Function jk_excite(q, n) returning {j, k}.
  - Function jk_next(q, j, k) for bench reference-model reuse.
- Sub-module jk_cell: one JK flip-flop with clk and active-low asynchronous reset, ports Q, J, K, clk, reset.
  - jk_excitation_counter instantiates WIDTH jk_cell instances via generate.
  - Next-state and excitation logic stay in the top module.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: hold reset=0 with en=1 for 3 clocks -> Q=0 throughout; deassert, en=1, up_dn=1 -> Q steps 1,2,3 on successive edges.
- Up wrap: from Q=8, en=1, up_dn=1 -> Q=9 with tc=1, then Q=0 with tc=0.
  - At Q=9: J_vec=0000, K_vec=1001.
- Down wrap: load 0, then en=1, up_dn=0 -> tc=1 at Q=0; next Q=9, with J_vec=1001, K_vec=0000 on that edge; then Q=8.
- Load priority and saturation:
  - load=1, en=1, load_val=5 -> Q=5.
  - load_val=13 -> Q=9.
  - load=1 at Q=9 with up_dn=1 -> tc=0 and no wrap.
- Hold: en=0 for 4 cycles at Q=6 -> Q stays 6, J_vec=K_vec=0000 every cycle.
- Async reset mid-count: at Q=7, pulse reset low for 2 ns between clock edges -> Q=0 immediately; next enabled up edge -> Q=1.
